// File: rtl/pico_prog_loader_if.sv
// Host-load and core-fetch signal bundle for pico_prog_loader.
// The master side is the host pins plus the core; the slave side is the loader.
interface pico_prog_loader_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic        ld_mode;
  logic        ld_strobe;
  logic [7:0]  ld_byte;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic [15:0] fetch_instr;
  logic        fetch_valid;
  logic        core_run;
  logic [AW:0] word_count;
  logic        ld_phase;
  logic        ovf;

  modport master (
    output ld_mode, ld_strobe, ld_byte, fetch_req, fetch_addr,
    input  fetch_instr, fetch_valid, core_run, word_count, ld_phase, ovf
  );

  modport slave (
    input  ld_mode, ld_strobe, ld_byte, fetch_req, fetch_addr,
    output fetch_instr, fetch_valid, core_run, word_count, ld_phase, ovf
  );
endinterface

// File: rtl/pico_prog_loader.sv
// Program loader: assembles host bytes into 16-bit words in a word RAM,
// then releases the core and serves its fetches with one cycle of latency.
module pico_prog_loader #(
  parameter int DEPTH = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  pico_prog_loader_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] WC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] WC_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] WC_ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic        byte_pulse_s;
  logic [7:0]  lo_q, lo_d;
  logic [AW:0] wc_q, wc_d;
  logic        phase_q, phase_d;
  logic        ovf_q, ovf_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        run_q, run_d;
  logic        we_s;
  logic [15:0] wdata_s;
  logic        hit_s;
  logic [15:0] mem_q [DEPTH];

  // The strobe is asynchronous: two flops resolve metastability, the third detects the rise.
  assign byte_pulse_s = s2_q & ~s3_q;
  assign hit_s        = {1'b0, bus.fetch_addr} < 9'(wc_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      lo_q    <= 8'h00;
      wc_q    <= WC_ZERO;
      phase_q <= 1'b0;
      ovf_q   <= 1'b0;
      instr_q <= 16'h0000;
      valid_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= bus.ld_strobe;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      lo_q    <= lo_d;
      wc_q    <= wc_d;
      phase_q <= phase_d;
      ovf_q   <= ovf_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      run_q   <= run_d;
    end
  end

  // Program RAM is deliberately left uninitialised by reset.
  always_ff @(posedge clk_i) begin
    if (we_s && !rst_i) begin
      mem_q[wc_q[AW-1:0]] <= wdata_s;
    end
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    wc_d    = wc_q;
    phase_d = phase_q;
    ovf_d   = ovf_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    we_s    = 1'b0;
    wdata_s = {bus.ld_byte, lo_q};
    case (state_q)
      ST_IDLE: begin
        if (bus.ld_mode) begin
          state_d = ST_LOAD;
          wc_d    = WC_ZERO;
          phase_d = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!bus.ld_mode) begin
          // Leaving load abandons a half-assembled word and any coincident byte.
          state_d = ST_RUN;
          phase_d = 1'b0;
        end else if (byte_pulse_s) begin
          if (!phase_q) begin
            lo_d    = bus.ld_byte;
            phase_d = 1'b1;
          end else if (wc_q == WC_FULL) begin
            ovf_d   = 1'b1;
            phase_d = 1'b0;
          end else begin
            we_s    = 1'b1;
            wc_d    = wc_q + WC_ONE;
            phase_d = 1'b0;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (bus.ld_mode) begin
          state_d = ST_LOAD;
          wc_d    = WC_ZERO;
          phase_d = 1'b0;
          ovf_d   = 1'b0;
        end else if (bus.fetch_req) begin
          valid_d = 1'b1;
          instr_d = hit_s ? mem_q[bus.fetch_addr[AW-1:0]] : 16'h0000;
        end else begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    run_d = (state_d == ST_RUN);
  end

  assign bus.fetch_instr = instr_q;
  assign bus.fetch_valid = valid_q;
  assign bus.core_run    = run_q;
  assign bus.word_count  = wc_q;
  assign bus.ld_phase    = phase_q;
  assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_pico_prog_loader.sv
// Directed bench for pico_prog_loader: loading, fetching, overflow, truncation and reset.
module tb_pico_prog_loader;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pico_prog_loader_if #(.DEPTH(DEPTH)) bus ();

  pico_prog_loader #(.DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bval(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // Called at a negedge; strobe high 3 clocks, low 3 clocks.
  task automatic send_byte(input logic [7:0] b);
    bus.ld_byte   = b;
    bus.ld_strobe = 1'b1;
    repeat (3) @(negedge clk);
    bus.ld_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_fetch(input string tag, input logic [7:0] addr, input logic [15:0] exp);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    @(negedge clk);
    bus.fetch_req  = 1'b0;
    check_eq({tag, "_valid"}, 32'(bus.fetch_valid), 32'd1);
    check_eq({tag, "_instr"}, 32'(bus.fetch_instr), 32'(exp));
  endtask

  initial begin
    rst            = 1'b1;
    bus.ld_mode    = 1'b0;
    bus.ld_strobe  = 1'b0;
    bus.ld_byte    = 8'h00;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = 8'h00;
    repeat (2) @(negedge clk);
    check_eq("rst_wc",    32'(bus.word_count),  32'd0);
    check_eq("rst_run",   32'(bus.core_run),    32'd0);
    check_eq("rst_phase", 32'(bus.ld_phase),    32'd0);
    check_eq("rst_ovf",   32'(bus.ovf),         32'd0);
    check_eq("rst_valid", 32'(bus.fetch_valid), 32'd0);
    check_eq("rst_instr", 32'(bus.fetch_instr), 32'h0);
    rst = 1'b0;

    // Basic two-word load
    bus.ld_mode = 1'b1;
    @(negedge clk);
    send_byte(8'h13);
    check_eq("ld1_phase", 32'(bus.ld_phase), 32'd1);
    send_byte(8'h25);
    send_byte(8'h01);
    send_byte(8'h80);
    check_eq("ld_wc",    32'(bus.word_count), 32'd2);
    check_eq("ld_phase", 32'(bus.ld_phase),   32'd0);
    check_eq("ld_run",   32'(bus.core_run),   32'd0);
    bus.fetch_req = 1'b1;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    check_eq("ld_fetch_ignored", 32'(bus.fetch_valid), 32'd0);

    bus.ld_mode = 1'b0;
    @(negedge clk);
    check_eq("run_run", 32'(bus.core_run),   32'd1);
    check_eq("run_wc",  32'(bus.word_count), 32'd2);
    do_fetch("f0", 8'd0, 16'h2513);
    do_fetch("f1", 8'd1, 16'h8001);
    @(negedge clk);
    check_eq("f_idle_valid", 32'(bus.fetch_valid), 32'd0);
    check_eq("f_hold_instr", 32'(bus.fetch_instr), 32'h8001);
    do_fetch("f2", 8'd2, 16'h0000);
    do_fetch("f200", 8'd200, 16'h0000);
    do_fetch("f1b", 8'd1, 16'h8001);

    // Fetch coincident with return to LOAD is dropped
    bus.ld_mode    = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 8'd0;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    check_eq("drop_valid", 32'(bus.fetch_valid), 32'd0);
    check_eq("drop_run",   32'(bus.core_run),    32'd0);
    check_eq("drop_wc",    32'(bus.word_count),  32'd0);
    check_eq("drop_hold",  32'(bus.fetch_instr), 32'h8001);

    // Odd byte count: trailing low byte discarded
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    check_eq("odd_wc",    32'(bus.word_count), 32'd1);
    check_eq("odd_phase", 32'(bus.ld_phase),   32'd1);
    bus.ld_mode = 1'b0;
    @(negedge clk);
    check_eq("odd_phase_clr", 32'(bus.ld_phase),   32'd0);
    check_eq("odd_wc_run",    32'(bus.word_count), 32'd1);
    do_fetch("odd_f0", 8'd0, 16'hBBAA);
    do_fetch("odd_f1", 8'd1, 16'h0000);

    // Overflow: 2*DEPTH+2 bytes
    bus.ld_mode = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2 * DEPTH + 2; i++) begin
      send_byte(bval(i));
      if (i == 2 * DEPTH - 1) begin
        check_eq("full_wc",  32'(bus.word_count), 32'(DEPTH));
        check_eq("full_ovf", 32'(bus.ovf),        32'd0);
      end
    end
    check_eq("ovf_wc",    32'(bus.word_count), 32'(DEPTH));
    check_eq("ovf_flag",  32'(bus.ovf),        32'd1);
    check_eq("ovf_phase", 32'(bus.ld_phase),   32'd0);
    bus.ld_mode = 1'b0;
    @(negedge clk);
    do_fetch("ovf_f0",   8'd0, {bval(1), bval(0)});
    do_fetch("ovf_f16",  8'(DEPTH), 16'h0000);
    do_fetch("ovf_flast", 8'(DEPTH - 1), {bval(2 * DEPTH - 1), bval(2 * DEPTH - 2)});
    bus.ld_mode = 1'b1;
    @(negedge clk);
    check_eq("reld_ovf",  32'(bus.ovf),         32'd0);
    check_eq("reld_wc",   32'(bus.word_count),  32'd0);
    check_eq("reld_hold", 32'(bus.fetch_instr), 32'({bval(2 * DEPTH - 1), bval(2 * DEPTH - 2)}));

    // Narrow strobe, then reset between low and high byte
    bus.ld_byte   = 8'h55;
    bus.ld_strobe = 1'b1;
    @(negedge clk);
    bus.ld_strobe = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("narrow_wc", 32'(bus.word_count), 32'd0);
    check_eq("narrow_phase_le1", 32'(bus.ld_phase <= 1'b1), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.ld_mode = 1'b0;
    check_eq("mid_rst_wc",    32'(bus.word_count),  32'd0);
    check_eq("mid_rst_phase", 32'(bus.ld_phase),    32'd0);
    check_eq("mid_rst_run",   32'(bus.core_run),    32'd0);
    check_eq("mid_rst_instr", 32'(bus.fetch_instr), 32'h0);
    send_byte(8'h77);
    check_eq("idle_byte_ignored", 32'(bus.ld_phase), 32'd0);
    bus.fetch_req = 1'b1;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    check_eq("idle_fetch_ignored", 32'(bus.fetch_valid), 32'd0);
    check_eq("idle_run",           32'(bus.core_run),    32'd0);
    bus.ld_mode = 1'b1;
    @(negedge clk);
    send_byte(8'h34);
    send_byte(8'h12);
    bus.ld_mode = 1'b0;
    @(negedge clk);
    do_fetch("post_rst_f0", 8'd0, 16'h1234 == 16'h1234 ? 16'h1234 : 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pico_prog_loader.md
Name: pico_prog_loader

Overview:
- Instruction-memory stage directly upstream of the pico RISC-V core.
- Host pins stream program bytes in through a slow, unsynchronised byte strobe. The block assembles 16-bit instruction words and stores them in a small word RAM.
- Once loading ends it releases the core (core_run) and serves the core's instruction fetches with 1-cycle latency.

Parameters:
- DEPTH, 16, number of 16-bit program words; power of two, 2..256.
- AW, $clog2(DEPTH), RAM address width (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ld_mode  in  1  level: 1 = load program, 0 = run; synchronous to clk
- ld_strobe  in  1  raw byte strobe from pin, asynchronous to clk
- ld_byte  in  8  program byte; held stable while ld_strobe high
- fetch_req  in  1  core fetch request, single-cycle
- fetch_addr  in  8  core PC (word address)
- fetch_instr  out  16  fetched instruction word, registered
- fetch_valid  out  1  1-cycle pulse: fetch_instr valid
- core_run  out  1  1 = core may execute (state RUN)
- word_count  out  AW+1  number of complete words stored
- ld_phase  out  1  1 = low byte held, waiting for high byte
- ovf  out  1  sticky: a word arrived with memory full

Behaviour:

Reset (rst=1 at a clock edge):
- State becomes IDLE.
- fetch_instr=0, fetch_valid=0, core_run=0, word_count=0, ld_phase=0, ovf=0.
- Synchroniser flops are cleared.
- RAM contents are not cleared.

Strobe conditioning:
- 3-flop chain s1→s2→s3 on ld_strobe; byte_pulse = s2 & ~s3.
- A ld_strobe rise before clock edge N produces byte_pulse in the cycle after edge N+1. ld_byte is sampled on edge N+2.
- Host must hold ld_strobe high ≥2 clk and low ≥2 clk.

States:
- IDLE:
  - ld_mode=1 → LOAD.
  - Otherwise stay; fetches are ignored.
- LOAD (core_run=0, fetch_valid forced 0). On entry: word_count←0, ld_phase←0, ovf←0, write pointer←0.
  - byte_pulse with ld_phase=0: lo_reg←ld_byte, ld_phase←1.
  - byte_pulse with ld_phase=1: word {ld_byte, lo_reg} is written at word_count (high byte first in the word); word_count+1; ld_phase←0.
  - If word_count==DEPTH at that point: no write, count unchanged, ovf←1, ld_phase←0.
  - ld_mode=0 → RUN. A pending low byte is discarded (ld_phase←0). A byte_pulse in that same cycle is ignored.
- RUN (core_run=1):
  - fetch_req=1 → on the next edge fetch_instr←RAM[fetch_addr] if fetch_addr < word_count, else 16'h0000 (NOP); fetch_valid=1 for exactly one cycle.
  - Back-to-back requests give back-to-back valid responses.
  - ld_mode=1 → LOAD; core_run drops on the same edge.
  - A fetch_req in that cycle is dropped (fetch_valid stays 0).
- Out of RUN, fetch_instr holds its last value.

Arithmetic and invariants:
- word_count saturates at DEPTH and never wraps.
- fetch_addr is compared at full 8 bits, so addresses ≥ DEPTH return NOP.
- rst asserted mid-load discards all progress; returns to IDLE.

Test Plan:
- Reset, then ld_mode=1 and 4 strobes with bytes 0x13,0x25,0x01,0x80 → word_count=2, RAM[0]=0x2513, RAM[1]=0x8001, ld_phase=0, core_run=0.
- From the above, ld_mode=0, fetch_req with addr 0 then 1 on consecutive cycles → fetch_valid high 2 cycles, fetch_instr 0x2513 then 0x8001; core_run=1.
- In RUN, fetch addr 2 and addr 200 → fetch_instr=0x0000 both, fetch_valid=1.
- Load 3 bytes 0xAA,0xBB,0xCC then ld_mode=0 → word_count=1, ld_phase=0; fetch addr 1 returns 0x0000.
- Load 2*DEPTH+2 bytes → word_count=DEPTH, ovf=1, RAM[DEPTH-1] holds the last legal word; re-enter LOAD clears ovf and word_count.
- ld_strobe pulse of 1 clk width, and rst asserted between the low and high byte → at most 0 or 1 byte captured, no spurious word; after rst: state IDLE, word_count=0, core_run=0.
